tournament_chooser_table: RTL
=============================

Name: tournament_chooser_table

Overview:
- Storage and update pipeline for the tournament chooser pattern-history table (PHT): 2^IDX_W entries of 2-bit counters selecting predictor A or predictor B.
- Serves one fetch-stage lookup per cycle.
- Accepts one branch-resolution update per cycle, applied as a 2-stage read-modify-write using the chooser saturating update rule.
- Sits between the fetch-side tournament mux (consumer of pred_use_b) and the EX/MEM branch-resolution logic (producer of per-predictor correctness).

Parameters:
- IDX_W, 7, table index width; depth = 2^IDX_W entries.
- INIT_VAL, 2'b01, value written to every entry by the reset sweep (weakly prefer A).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ready  out  1  high once the init sweep has completed
- lk_valid  in  1  lookup request
- lk_pc  in  32  fetch PC
- lk_ghr  in  IDX_W  global history at fetch
- lk_resp_valid  out  1  lookup response valid, 1 cycle after request
- lk_state  out  2  counter value read
- lk_use_b  out  1  lk_state[1]; 1 = use predictor B
- upd_valid  in  1  resolution update
- upd_pc  in  32  branch PC
- upd_ghr  in  IDX_W  history snapshot taken at fetch
- upd_a_correct  in  1  predictor A was correct
- upd_b_correct  in  1  predictor B was correct

Behaviour:
- Index: idx = pc[IDX_W+1:2] XOR ghr. The same hash is used for lookup and update.
- Counter encoding: 00 = strong A, 01 = weak A, 10 = weak B, 11 = strong B.
- Update rule:
  - a == b: no change, and no array write.
  - a = 1, b = 0: decrement, saturating at 00.
  - a = 0, b = 1: increment, saturating at 11.
- Reset:
  - ready, lk_resp_valid, lk_state, lk_use_b = 0.
  - All pipeline valids cleared; FSM enters INIT with sweep pointer = 0.
  - Array contents are not reset directly.
- FSM INIT:
  - Each cycle write INIT_VAL to array[ptr], then ptr++.
  - After writing entry 2^IDX_W-1, go to READY.
  - The sweep takes exactly 2^IDX_W cycles; ready rises on the following cycle.
- During INIT:
  - lk_valid is ignored (no response).
  - upd_valid is dropped; no state change.
- FSM READY: stays in READY until rst.
- Lookup:
  - Registered read; lk_resp_valid pulses 1 cycle after an accepted lk_valid.
  - If an update write (U2) to the same idx commits in the lookup's request cycle, the response returns the newly written value (write-first bypass).
- Update pipeline:
  - U1 (cycle after acceptance): register idx, a, b; read array[idx].
  - U2: compute the new value from the U1 data and write it if a != b.
  - Forwarding: if U2 writes idx X in the same cycle U1 reads X, U1 uses U2's new value. Back-to-back updates to one entry must accumulate; no update is lost.
  - Throughput: 1 update per cycle, no stall output.
- Simultaneous lookup and update to different or same indices in one cycle: both proceed.
- rst asserted mid-sweep or mid-update: in-flight update discarded, sweep restarts from entry 0.

Optional Feature:
- Macro CHOOSER_STATS_EN.
- When defined, add outputs:
  - stat_updates (32): count of accepted upd_valid in READY.
  - stat_flips (32): count of U2 writes where lk_use_b-equivalent bit [1] changed.
- Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle: ready = 0 for 128 cycles and 1 on cycle 129; lookups of idx 0, 5, 127 then return lk_state = 01, lk_use_b = 0.
- Update idx 3 with a = 0, b = 1 on two consecutive cycles: lookup returns 11, lk_use_b = 1, confirming forwarding accumulates.
- From 11 at idx 3, apply three updates with a = 1, b = 0, then a fourth: states step 10, 01, 00, then stay at 00.
- Updates with a = b = 1 and a = b = 0 on idx 9 (value 01): idx 9 stays 01; with CHOOSER_STATS_EN, stat_updates = 2 and stat_flips = 0.
- lk_valid issued the same cycle U2 writes 10 to idx 20 (old value 01): lk_resp_valid next cycle with lk_state = 10.
- Assert rst at sweep cycle 60, then during an in-flight update to idx 3: ready drops, a full 128-cycle sweep reruns, and idx 3 reads 01 afterwards.

Source files
------------

// File: rtl/tournament_chooser_table.sv
// Tournament chooser PHT: 2-bit counters with a reset init sweep, registered lookup and
// a 2-stage read-modify-write update path. Define CHOOSER_STATS_EN to add stat counters.
module tournament_chooser_table #(
    parameter int unsigned IDX_W    = 7,
    parameter logic [1:0]  INIT_VAL = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             lk_valid,
    input  logic [31:0]      lk_pc,
    input  logic [IDX_W-1:0] lk_ghr,
    output logic             lk_resp_valid,
    output logic [1:0]       lk_state,
    output logic             lk_use_b,
`ifdef CHOOSER_STATS_EN
    output logic [31:0]      stat_updates,
    output logic [31:0]      stat_flips,
`endif
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [IDX_W-1:0] upd_ghr,
    input  logic             upd_a_correct,
    input  logic             upd_b_correct
);

    localparam int unsigned      DEPTH   = 1 << IDX_W;
    localparam logic [IDX_W-1:0] PTR_ONE = 1;

    typedef enum logic {StInit, StReady} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [1:0]       mem [DEPTH];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic             lk_acc, upd_acc;
    logic [1:0]       lk_rd;

    logic             u1_valid_q, u1_a_q, u1_b_q;
    logic [IDX_W-1:0] u1_idx_q;
    logic [1:0]       u1_cur;

    logic             u2_valid_q, u2_a_q, u2_b_q;
    logic [IDX_W-1:0] u2_idx_q;
    logic [1:0]       u2_cur_q, u2_new;
    logic             u2_we;

    // Only the hashed PC bits take part in indexing.
    logic unused_pc;
    assign unused_pc = ^{lk_pc[31:IDX_W+2], lk_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};

    assign lk_idx   = lk_pc[IDX_W+1:2] ^ lk_ghr;
    assign upd_idx  = upd_pc[IDX_W+1:2] ^ upd_ghr;
    assign lk_acc   = lk_valid & ready;
    assign upd_acc  = upd_valid & ready;
    assign lk_use_b = lk_state[1];

    always_comb begin
        u2_new = u2_cur_q;
        if (u2_a_q && !u2_b_q) begin
            if (u2_cur_q != 2'b00) u2_new = u2_cur_q - 2'd1;
        end else if (!u2_a_q && u2_b_q) begin
            if (u2_cur_q != 2'b11) u2_new = u2_cur_q + 2'd1;
        end
    end

    assign u2_we = u2_valid_q & (u2_a_q ^ u2_b_q);

    // Write-first forwarding of the committing U2 value to both readers.
    assign u1_cur = (u2_we && (u2_idx_q == u1_idx_q)) ? u2_new : mem[u1_idx_q];
    assign lk_rd  = (u2_we && (u2_idx_q == lk_idx))   ? u2_new : mem[lk_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StInit;
            ptr_q         <= '0;
            ready         <= 1'b0;
            lk_resp_valid <= 1'b0;
            lk_state      <= 2'b00;
            u1_valid_q    <= 1'b0;
            u1_idx_q      <= '0;
            u1_a_q        <= 1'b0;
            u1_b_q        <= 1'b0;
            u2_valid_q    <= 1'b0;
            u2_idx_q      <= '0;
            u2_cur_q      <= 2'b00;
            u2_a_q        <= 1'b0;
            u2_b_q        <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    ptr_q <= ptr_q + PTR_ONE;
                    if (ptr_q == {IDX_W{1'b1}}) begin
                        state_q <= StReady;
                        ready   <= 1'b1;
                    end
                end
                StReady: state_q <= StReady;
            endcase

            lk_resp_valid <= lk_acc;
            if (lk_acc) lk_state <= lk_rd;

            u1_valid_q <= upd_acc;
            if (upd_acc) begin
                u1_idx_q <= upd_idx;
                u1_a_q   <= upd_a_correct;
                u1_b_q   <= upd_b_correct;
            end

            u2_valid_q <= u1_valid_q;
            if (u1_valid_q) begin
                u2_idx_q <= u1_idx_q;
                u2_cur_q <= u1_cur;
                u2_a_q   <= u1_a_q;
                u2_b_q   <= u1_b_q;
            end
        end
    end

    // Array has no reset; the sweep owns the write port until ready.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem[ptr_q] <= INIT_VAL;
        end else if (u2_we) begin
            mem[u2_idx_q] <= u2_new;
        end
    end

`ifdef CHOOSER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_updates <= 32'd0;
            stat_flips   <= 32'd0;
        end else begin
            if (upd_acc && (stat_updates != 32'hFFFF_FFFF)) stat_updates <= stat_updates + 32'd1;
            if (u2_we && (u2_new[1] != u2_cur_q[1]) && (stat_flips != 32'hFFFF_FFFF)) begin
                stat_flips <= stat_flips + 32'd1;
            end
        end
    end
`endif

endmodule
